// File: rtl/notch_filter_sequencer.sv
// Notch filter sequencer: paces ADC sample requests from a programmable tick, forwards each
// acknowledged sample to the filter with a one-cycle strobe, flushes the filter on a shift
// change, and reports when the filter output has settled.
module notch_filter_sequencer #(
  parameter int unsigned W         = 20,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned K_INIT    = 4,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned SETTLE    = 8
) (
  input  logic                qzt_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [DIV_W-1:0]    div,
  input  logic [3:0]          k_req,
  input  logic                k_req_valid,
  output logic                adc_req,
  input  logic                adc_ack,
  input  logic signed [W-1:0] adc_data,
  output logic                filt_clk_in,
  output logic signed [W-1:0] filt_vin,
  output logic [3:0]          filt_k,
  output logic                filt_reset,
  output logic                out_valid,
  output logic                overrun
);

  localparam int unsigned FlushW  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int unsigned SettleW = $clog2(SETTLE + 1);
  localparam logic [FlushW-1:0]  FlushLast = FlushW'(FLUSH_CYC - 1);
  localparam logic [SettleW-1:0] SettleMax = SettleW'(SETTLE);
  localparam logic [DIV_W-1:0]   MinLim    = DIV_W'(3);

  typedef enum logic [1:0] {StFlush, StWaitTick, StReq, StStrobe} state_e;

  state_e              state_q, state_d;
  logic [FlushW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DIV_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [3:0]          pend_k_q, pend_k_d;
  logic                pend_v_q, pend_v_d;
  logic signed [W-1:0] filt_vin_q, filt_vin_d;
  logic [3:0]          filt_k_q, filt_k_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;
  logic                enable_q;

  logic [DIV_W-1:0] tick_lim;
  logic             tick;
  logic             apply_k;
  logic             settle_clr;

  // Period is clamped so there are always at least four cycles between ticks.
  assign tick_lim = (div < MinLim) ? MinLim : div;
  assign tick     = enable && (tick_cnt_q == tick_lim);

  // Tick counter: free-runs 0..tick_lim while enabled, parked at zero otherwise.
  always_comb begin
    tick_cnt_d = '0;
    if (enable && (tick_cnt_q < tick_lim)) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  // Sequencer next state, k handling, settle tracking and overrun detection.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    filt_vin_d  = filt_vin_q;
    filt_k_d    = filt_k_q;
    pend_k_d    = pend_k_q;
    pend_v_d    = pend_v_q;
    settle_d    = settle_q;
    overrun_d   = overrun_q;
    apply_k     = 1'b0;
    settle_clr  = enable_q && !enable;

    unique case (state_q)
      StFlush: begin
        if (flush_cnt_q == FlushLast) begin
          state_d = StWaitTick;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      StWaitTick: begin
        // A pending shift change beats a coincident tick.
        if (pend_v_q) begin
          apply_k     = 1'b1;
          state_d     = StFlush;
          flush_cnt_d = '0;
          filt_k_d    = pend_k_q;
        end else if (tick) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (adc_ack) begin
          state_d    = StStrobe;
          filt_vin_d = adc_data;
        end
      end
      StStrobe: state_d = StWaitTick;
      default:  state_d = StFlush;
    endcase

    if (tick && ((state_q != StWaitTick) || pend_v_q)) begin
      overrun_d = 1'b1;
    end

    // Newest request always overwrites; a same-cycle request survives the apply.
    if (k_req_valid) begin
      pend_v_d = 1'b1;
      pend_k_d = (k_req == 4'd0) ? 4'd1 : k_req;
    end else if (apply_k) begin
      pend_v_d = 1'b0;
    end

    if (apply_k || settle_clr) begin
      settle_d = '0;
    end else if ((state_q == StStrobe) && (settle_q != SettleMax)) begin
      settle_d = settle_q + 1'b1;
    end

    out_valid_d = !(apply_k || settle_clr) && (settle_q == SettleMax);
  end

  // State registers; reset aborts any handshake in flight and holds the filter in reset.
  always_ff @(posedge qzt_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StFlush;
      flush_cnt_q <= '0;
      tick_cnt_q  <= '0;
      settle_q    <= '0;
      pend_k_q    <= '0;
      pend_v_q    <= 1'b0;
      filt_vin_q  <= '0;
      filt_k_q    <= 4'(K_INIT);
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      settle_q    <= settle_d;
      pend_k_q    <= pend_k_d;
      pend_v_q    <= pend_v_d;
      filt_vin_q  <= filt_vin_d;
      filt_k_q    <= filt_k_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      enable_q    <= enable;
    end
  end

  assign adc_req     = (state_q == StReq);
  assign filt_clk_in = (state_q == StStrobe);
  assign filt_reset  = (state_q == StFlush);
  assign filt_vin    = filt_vin_q;
  assign filt_k      = filt_k_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_notch_filter_sequencer.sv
// Bench for notch_filter_sequencer: randomized converter/k/enable stimulus compared every cycle
// against a behavioural model, plus directed scenarios for clamping, overrun, k changes and reset.
module tb_notch_filter_sequencer;

  localparam int W         = 20;
  localparam int DIV_W     = 16;
  localparam int K_INIT    = 4;
  localparam int FLUSH_CYC = 2;
  localparam int SETTLE    = 8;

  localparam int MFlush  = 0;
  localparam int MWait   = 1;
  localparam int MReq    = 2;
  localparam int MStrobe = 3;

  logic                qzt_clk;
  logic                reset;
  logic                enable;
  logic [DIV_W-1:0]    div;
  logic [3:0]          k_req;
  logic                k_req_valid;
  logic                adc_req;
  logic                adc_ack;
  logic signed [W-1:0] adc_data;
  logic                filt_clk_in;
  logic signed [W-1:0] filt_vin;
  logic [3:0]          filt_k;
  logic                filt_reset;
  logic                out_valid;
  logic                overrun;

  notch_filter_sequencer #(
    .W(W), .DIV_W(DIV_W), .K_INIT(K_INIT), .FLUSH_CYC(FLUSH_CYC), .SETTLE(SETTLE)
  ) dut (
    .qzt_clk(qzt_clk), .reset(reset), .enable(enable), .div(div), .k_req(k_req),
    .k_req_valid(k_req_valid), .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
    .filt_clk_in(filt_clk_in), .filt_vin(filt_vin), .filt_k(filt_k), .filt_reset(filt_reset),
    .out_valid(out_valid), .overrun(overrun)
  );

  initial qzt_clk = 1'b0;
  always #5 qzt_clk = ~qzt_clk;

  int n_checks;
  int n_pass;

  // Model state: what the outputs should be in the current cycle.
  int                  m_st;
  int                  m_flush_left;
  logic signed [W-1:0] m_vin;
  int                  m_k;
  int                  m_pend_k;
  bit                  m_pend_v;
  int                  m_pulses;
  bit                  m_valid;
  bit                  m_ovr;
  bit                  m_en_last;
  int                  t;
  int                  t_en;

  int req_age;
  int flush_rises;
  int dut_pulses;
  bit prev_fr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, t, got, exp);
  endtask

  task automatic model_reset();
    m_st         = MFlush;
    m_flush_left = FLUSH_CYC;
    m_vin        = '0;
    m_k          = K_INIT;
    m_pend_k     = 0;
    m_pend_v     = 1'b0;
    m_pulses     = 0;
    m_valid      = 1'b0;
    m_ovr        = 1'b0;
    m_en_last    = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    int lim;
    int n_st;
    bit tick;
    bit clr;
    bit apply;
    lim = (int'(div) < 3) ? 3 : int'(div);
    if (enable && !m_en_last) t_en = t;
    tick  = enable && (((t - t_en) % (lim + 1)) == lim);
    clr   = m_en_last && !enable;
    apply = (m_st == MWait) && m_pend_v;
    if (tick && ((m_st != MWait) || m_pend_v)) m_ovr = 1'b1;
    m_valid = !(apply || clr) && (m_pulses >= SETTLE);
    if (apply || clr) m_pulses = 0;
    else if (m_st == MStrobe) m_pulses++;
    n_st = m_st;
    case (m_st)
      MFlush: begin
        if (m_flush_left == 1) n_st = MWait;
        else m_flush_left--;
      end
      MWait: begin
        if (apply) begin
          n_st         = MFlush;
          m_flush_left = FLUSH_CYC;
          m_k          = m_pend_k;
        end else if (tick) begin
          n_st = MReq;
        end
      end
      MReq: begin
        if (adc_ack) begin
          n_st  = MStrobe;
          m_vin = adc_data;
        end
      end
      default: n_st = MWait;
    endcase
    if (k_req_valid) begin
      m_pend_v = 1'b1;
      m_pend_k = (k_req == 4'd0) ? 1 : int'(k_req);
    end else if (apply) begin
      m_pend_v = 1'b0;
    end
    m_st      = n_st;
    m_en_last = enable;
    t++;
  endtask

  task automatic check_outputs();
    check_eq("adc_req", 32'(adc_req), 32'(m_st == MReq));
    check_eq("filt_clk_in", 32'(filt_clk_in), 32'(m_st == MStrobe));
    check_eq("filt_reset", 32'(filt_reset), 32'(m_st == MFlush));
    check_eq("filt_vin", 32'(filt_vin), 32'(m_vin));
    check_eq("filt_k", 32'(filt_k), 32'(m_k));
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  // One clock cycle, entered and left at a falling edge: check, drive, model, advance.
  task automatic cycle(input bit en, input int dv, input int lat, input bit spur, input int kprob,
                       input int force_k);
    check_outputs();
    if (filt_reset && !prev_fr) flush_rises++;
    prev_fr = filt_reset;
    if (filt_clk_in) dut_pulses++;
    enable      = en;
    div         = DIV_W'(dv);
    k_req       = 4'($urandom_range(0, 15));
    k_req_valid = 1'b0;
    if (force_k >= 0) begin
      k_req_valid = 1'b1;
      k_req       = 4'(force_k);
    end else if ((kprob > 0) && ($urandom_range(0, kprob - 1) == 0)) begin
      k_req_valid = 1'b1;
    end
    if (m_st == MReq) begin
      adc_ack = (req_age >= lat);
      req_age++;
    end else begin
      req_age = 0;
      adc_ack = spur && ($urandom_range(0, 3) == 0);
    end
    adc_data = W'($urandom);
    model_step();
    @(negedge qzt_clk);
  endtask

  task automatic wait_req(input int dv, input int lat);
    for (int i = 0; (i < 100) && (m_st != MReq); i++) cycle(1'b1, dv, lat, 1'b0, 0, -1);
    check_eq("reach_req", 32'(adc_req), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got no finish, expected finish within bound");
    $fatal(1);
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    t           = 0;
    t_en        = 0;
    req_age     = 0;
    flush_rises = 0;
    dut_pulses  = 0;
    prev_fr     = 1'b0;
    reset       = 1'b0;
    enable      = 1'b0;
    div         = DIV_W'(9);
    k_req       = 4'd0;
    k_req_valid = 1'b0;
    adc_ack     = 1'b0;
    adc_data    = '0;
    model_reset();
    repeat (3) begin
      @(negedge qzt_clk);
      check_outputs();
    end
    reset = 1'b1;

    // div=9, ack one cycle after request.
    repeat (150) cycle(1'b1, 9, 1, 1'b0, 0, -1);
    check_eq("valid_div9", 32'(out_valid), 32'd1);
    check_eq("no_ovr_div9", 32'(overrun), 32'd0);

    // Falling enable, then div=1 clamped to a 4-cycle period.
    repeat (2) cycle(1'b0, 1, 1, 1'b0, 0, -1);
    check_eq("valid_en_fall", 32'(out_valid), 32'd0);
    dut_pulses = 0;
    repeat (60) cycle(1'b1, 1, 1, 1'b0, 0, -1);
    check_eq("pulses_div1", 32'(dut_pulses >= 14), 32'd1);
    check_eq("no_ovr_div1", 32'(overrun), 32'd0);

    // Slow converter forces overrun; later handshakes still complete.
    repeat (2) cycle(1'b0, 9, 1, 1'b0, 0, -1);
    repeat (40) cycle(1'b1, 9, 12, 1'b0, 0, -1);
    check_eq("ovr_slow_ack", 32'(overrun), 32'd1);
    repeat (40) cycle(1'b1, 9, 1, 1'b0, 0, -1);

    // k=6 requested mid-handshake.
    wait_req(9, 2);
    cycle(1'b1, 9, 2, 1'b0, 0, 6);
    repeat (120) cycle(1'b1, 9, 2, 1'b0, 0, -1);
    check_eq("k6_applied", 32'(filt_k), 32'd6);
    check_eq("k6_resettled", 32'(out_valid), 32'd1);

    // k=0 clamps to 1.
    wait_req(9, 2);
    cycle(1'b1, 9, 2, 1'b0, 0, 0);
    repeat (40) cycle(1'b1, 9, 2, 1'b0, 0, -1);
    check_eq("k0_clamped", 32'(filt_k), 32'd1);

    // Two requests in one interval give a single flush with the last value.
    wait_req(9, 5);
    flush_rises = 0;
    cycle(1'b1, 9, 5, 1'b0, 0, 3);
    cycle(1'b1, 9, 5, 1'b0, 0, 7);
    repeat (40) cycle(1'b1, 9, 5, 1'b0, 0, -1);
    check_eq("single_flush", 32'(flush_rises), 32'd1);
    check_eq("k_last_wins", 32'(filt_k), 32'd7);

    // Randomized traffic.
    for (int b = 0; b < 30; b++) begin
      int dv;
      int lat;
      dv  = $urandom_range(0, 14);
      lat = ($urandom_range(0, 5) == 0) ? 11 : $urandom_range(0, 3);
      repeat ($urandom_range(1, 3)) cycle(1'b0, dv, lat, 1'b1, 30, -1);
      repeat (50) cycle($urandom_range(0, 40) != 0, dv, lat, 1'b1, 30, -1);
    end

    // Reset asserted while a request is outstanding.
    repeat (2) cycle(1'b0, 9, 5, 1'b0, 0, -1);
    wait_req(9, 5);
    @(posedge qzt_clk);
    #2;
    check_eq("req_before_rst", 32'(adc_req), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (3) begin
      @(negedge qzt_clk);
      check_outputs();
    end
    reset      = 1'b1;
    dut_pulses = 0;
    repeat (60) cycle(1'b1, 9, 1, 1'b0, 0, -1);
    check_eq("resume_after_rst", 32'(dut_pulses > 0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/notch_filter_sequencer.md
NOTCH_FILTER_SEQUENCER -- requirements
Module: notch_filter_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 20, giving the sample width.
REQ-002 The block SHALL have parameter DIV_W, default 16, giving the sample-period counter width.
REQ-003 The block SHALL have parameter K_INIT, default 4, giving the filter shift after reset.
REQ-004 The block SHALL have parameter FLUSH_CYC, default 2, giving the number of cycles filt_reset is held during a flush.
REQ-005 The block SHALL have parameter SETTLE, default 8, giving the number of samples strobed after a flush before out_valid.
REQ-006 Port qzt_clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port enable, input, 1: run sampling when high.
REQ-009 Port div, input, DIV_W: sample period in qzt_clk cycles, minus 1.
REQ-010 Port k_req, input, 4: requested filter shift.
REQ-011 Port k_req_valid, input, 1: one-cycle pulse requesting a k change.
REQ-012 Port adc_req, output, 1: sample request to the converter.
REQ-013 Port adc_ack, input, 1: converter acknowledge; adc_data is valid in the same cycle.
REQ-014 Port adc_data, input, W signed: sample from the converter.
REQ-015 Port filt_clk_in, output, 1: sample strobe to the filter's clk_in.
REQ-016 Port filt_vin, output, W signed: sample to the filter's Vin.
REQ-017 Port filt_k, output, 4: shift to the filter's k.
REQ-018 Port filt_reset, output, 1: active-high reset to the filter.
REQ-019 Port out_valid, output, 1: the filter output has settled.
REQ-020 Port overrun, output, 1: sticky flag, a tick was missed.

Function
REQ-021 States SHALL be FLUSH, WAIT_TICK, REQ and STROBE.
- FLUSH: filt_reset=1 for FLUSH_CYC cycles, then WAIT_TICK.
- WAIT_TICK -> REQ on tick.
- REQ -> STROBE on adc_ack.
- STROBE -> WAIT_TICK after 1 cycle.
REQ-022 Tick counter behaviour SHALL be as follows.
- Counts 0..max(div,3) while enable=1, then wraps to 0.
- A tick occurs in the cycle the counter equals max(div,3), so there are at least 4 cycles between ticks.
- Counter is held at 0 when enable=0.
REQ-023 A tick in WAIT_TICK SHALL cause adc_req=1 from the next cycle, held until the cycle after adc_ack is seen.
- adc_ack outside REQ is ignored.
REQ-024 On adc_ack in cycle a:
- filt_vin<=adc_data, visible at a+1.
- adc_req=0 at a+1.
- filt_clk_in=1 for exactly cycle a+1, otherwise 0.
- filt_vin is held until the next ack.
REQ-025 A tick arriving in REQ, STROBE or FLUSH SHALL be dropped and SHALL set overrun=1.
- overrun is cleared only by reset.
REQ-026 k_req_valid SHALL latch k_req into a pending register in any state.
- A later request overwrites a still-pending one; the last request wins.
- k_req=0 is clamped to 1.
REQ-027 A pending k SHALL be applied only on WAIT_TICK entry or while in WAIT_TICK:
- filt_k<=pending;
- go to FLUSH;
- clear pending, out_valid and the settle count.
- A handshake in progress completes before the k change takes effect.
REQ-028 If a tick and a pending k coincide in WAIT_TICK, FLUSH SHALL win and the tick is counted as overrun.
REQ-029 Settle behaviour SHALL be as follows.
- The settle counter increments on each filt_clk_in pulse and saturates at SETTLE.
- out_valid=1 from the cycle after it reaches SETTLE.
REQ-030 Falling enable SHALL clear out_valid and the settle count.
- Falling enable does not flush the filter.
- An in-flight REQ/STROBE still completes.

Reset
REQ-031 While reset=0, outputs SHALL be: adc_req=0, filt_clk_in=0, filt_vin=0, filt_k=K_INIT, filt_reset=1, out_valid=0, overrun=0.
- Tick counter, settle count and pending are also cleared.
REQ-032 After reset release the block SHALL enter FLUSH with its cycle count at 0, so filt_reset stays high for FLUSH_CYC more cycles.
REQ-033 Reset asserted mid-handshake SHALL abort it immediately, dropping adc_req with no filt_clk_in pulse.

Verification
REQ-034 div=9, enable=1, ack one cycle after each req:
- expect a tick every 10 cycles;
- expect one filt_clk_in pulse per tick, with filt_vin equal to the acked sample;
- expect out_valid after the 8th pulse;
- expect overrun=0.
REQ-035 div=1 -> ticks every 4 cycles (clamped).
REQ-036 div=9, ack delayed 12 cycles -> overrun=1; the next handshake completes normally.
REQ-037 Pulse k_req=6 while in REQ:
- filt_k stays 4 until the STROBE completes;
- then filt_reset=1 for 2 cycles and filt_k=6;
- out_valid drops and returns after 8 more pulses.
REQ-038 k_req=0 -> filt_k=1; two k pulses 3 then 7 in one interval -> a single flush with filt_k=7.
REQ-039 Assert reset while adc_req=1:
- outputs go to their reset values asynchronously;
- after release, filt_reset stays high 2 cycles, then sampling resumes.
